// File: rtl/trace_pkg.sv
// Shared definitions for the trace capture block: FSM state encoding.
package trace_pkg;

    // Capture FSM states; the encoding is visible on the state output.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/trace_ram.sv
// Trace buffer storage: simple dual-port RAM, one write port and one
// registered read port. The array itself is never reset, so captured data
// survives reset; only the read register is cleared.
module trace_ram #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_p1;

    // Write port: one sample per cycle when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: registered, so a same-cycle write to rd_addr returns the old word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_p1 <= '0;
        end else begin
            rd_data_p1 <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_p1;

endmodule

// File: rtl/trace_capture.sv
// Logic-analyser style trace capture: records din on sample_en into a
// circular buffer once armed, keeps POST_TRIG samples after the trigger
// sample, then freezes until re-armed. Buffer is read back through rd_addr.
module trace_capture
    import trace_pkg::*;
#(
    parameter int  WIDTH     = 8,
    parameter int  DEPTH     = 16,
    parameter int  POST_TRIG = 8,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic             abort,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] din,
    input  logic             trig,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic [1:0]       state,
    output logic             done,
    output logic [AW-1:0]    trig_pos,
    output logic [AW-1:0]    wr_ptr,
    output logic [AW:0]      fill
);

    state_t          st_q, st_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   trig_pos_q, trig_pos_d;
    logic [AW-1:0]   post_q, post_d;
    logic [AW:0]     fill_q, fill_d;
    logic            we;

    // Valid-sample count increments until the buffer has wrapped once.
    function automatic logic [AW:0] fill_sat_inc(input logic [AW:0] v);
        if (v >= (AW+1)'(DEPTH)) begin
            return (AW+1)'(DEPTH);
        end
        return v + (AW+1)'(1);
    endfunction

    // State, pointer and counter registers; buffer contents are not touched by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q       <= IDLE;
            wr_ptr_q   <= '0;
            trig_pos_q <= '0;
            post_q     <= '0;
            fill_q     <= '0;
        end else begin
            st_q       <= st_d;
            wr_ptr_q   <= wr_ptr_d;
            trig_pos_q <= trig_pos_d;
            post_q     <= post_d;
            fill_q     <= fill_d;
        end
    end

    // Next-state and write control; abort overrides everything, including the write.
    always_comb begin
        st_d       = st_q;
        wr_ptr_d   = wr_ptr_q;
        trig_pos_d = trig_pos_q;
        post_d     = post_q;
        fill_d     = fill_q;
        we         = 1'b0;
        if (abort) begin
            st_d = IDLE;
        end else begin
            case (st_q)
                IDLE, DONE: begin
                    if (arm) begin
                        st_d     = ARMED;
                        wr_ptr_d = '0;
                        fill_d   = '0;
                    end
                end
                ARMED: begin
                    if (sample_en) begin
                        we       = 1'b1;
                        wr_ptr_d = wr_ptr_q + AW'(1);
                        fill_d   = fill_sat_inc(fill_q);
                        if (trig) begin
                            trig_pos_d = wr_ptr_q;
                            post_d     = AW'(POST_TRIG);
                            st_d       = (POST_TRIG == 0) ? DONE : POST;
                        end
                    end
                end
                POST: begin
                    if (sample_en) begin
                        we       = 1'b1;
                        wr_ptr_d = wr_ptr_q + AW'(1);
                        fill_d   = fill_sat_inc(fill_q);
                        post_d   = post_q - AW'(1);
                        if (post_q <= AW'(1)) begin
                            st_d = DONE;
                        end
                    end
                end
                default: st_d = IDLE;
            endcase
        end
    end

    trace_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .wr_addr (wr_ptr_q),
        .wr_data (din),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign state    = st_q;
    assign done     = (st_q == DONE);
    assign trig_pos = trig_pos_q;
    assign wr_ptr   = wr_ptr_q;
    assign fill     = fill_q;

endmodule

// File: doc/trace_capture.md
TRACE_CAPTURE -- requirements
Module: trace_capture

Interface
REQ-001 SHALL have parameter WIDTH, default 8, sample width in bits (≥1).
REQ-002 SHALL have parameter DEPTH, default 16, buffer entries (power of 2, ≥4); AW = log2(DEPTH).
REQ-003 SHALL have parameter POST_TRIG, default 8, samples stored after the trigger sample (0..DEPTH-1).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low.
REQ-006 arm  input  1  one-cycle request to start a capture.
REQ-007 abort  input  1  forces return to IDLE.
REQ-008 sample_en  input  1  din is valid this cycle.
REQ-009 din  input  WIDTH  sampled bus value (e.g. BUS1, ALU result).
REQ-010 trig  input  1  trigger condition, qualified by sample_en.
REQ-011 rd_addr  input  AW  readback address.
REQ-012 rd_data  output  WIDTH  buffer content at rd_addr, registered.
REQ-013 state  output  2  IDLE=0, ARMED=1, POST=2, DONE=3.
REQ-014 done  output  1  high while state==DONE.
REQ-015 trig_pos  output  AW  address holding the trigger sample.
REQ-016 wr_ptr  output  AW  next write address.
REQ-017 fill  output  AW+1  valid sample count, saturating at DEPTH.

Function
REQ-018 IDLE: no buffer writes; arm -> ARMED with wr_ptr=0, fill=0.
REQ-019 ARMED: sample_en writes din to mem[wr_ptr], wr_ptr+1 mod DEPTH (wraps DEPTH-1 -> 0), fill+1 saturating at DEPTH.
REQ-020 ARMED with sample_en&&trig: sample written, trig_pos<=wr_ptr, post counter<=POST_TRIG, next state POST; if POST_TRIG==0 next state DONE.
REQ-021 trig without sample_en SHALL be ignored in every state.
REQ-022 POST: each sample_en writes as REQ-019 and decrements post counter; write that brings counter to 0 moves to DONE on same edge.
REQ-023 DONE: no writes; wr_ptr, trig_pos, fill frozen; arm -> ARMED restarting per REQ-018.
REQ-024 arm in ARMED or POST SHALL be ignored.
REQ-025 abort in any state -> IDLE next edge, no write that cycle; abort wins over simultaneous arm, trig, sample_en.
REQ-026 Buffer contents SHALL NOT be cleared by arm, abort or reset.
REQ-027 rd_data <= mem[rd_addr] every cycle, 1-cycle latency, any state; same-cycle read/write of one address returns old data.
REQ-028 Oldest valid sample address SHALL equal wr_ptr when fill==DEPTH, else 0.

Reset
REQ-029 rst low SHALL immediately force state=IDLE, done=0, wr_ptr=0, trig_pos=0, fill=0, post counter=0, rd_data=0.
REQ-030 Reset mid-capture SHALL discard the capture; first edge after rst high behaves as IDLE.

Structure
REQ-031 Package trace_pkg SHALL hold the state encoding constants (IDLE/ARMED/POST/DONE).
REQ-032 Storage SHALL be a sub-module trace_ram (simple dual-port, 1 write, 1 registered read, WIDTH x DEPTH, no reset on array).
REQ-033 Control FSM, pointers and counters SHALL reside in trace_capture.

Verification (WIDTH=8, DEPTH=16, POST_TRIG=8)
REQ-034 Reset, arm, 5 samples 0x01..0x05, trig on 0x05 -> trig_pos=4, state=POST; 8 more samples -> DONE, wr_ptr=13, fill=13.
REQ-035 arm, 20 samples 0x00..0x13 no trig -> wr_ptr=4, fill=16, rd_addr=3 returns 0x13, rd_addr=4 returns 0x04 one cycle later.
REQ-036 trig high with sample_en low in ARMED -> state stays ARMED, no write; trig_pos unchanged.
REQ-037 abort and arm same cycle in POST -> IDLE, done=0; later rd_addr=0 still returns earlier data.
REQ-038 rst low during POST after 3 post samples -> state=0, fill=0 asynchronously; arm then trig on first sample -> trig_pos=0.
REQ-039 POST_TRIG=0 build: arm, sample 0xAA with trig -> DONE next edge, trig_pos=0, fill=1.
